// File: rtl/tmr_pkg.sv
// Shared types and constants for the triple-redundant scrubbing register.
package tmr_pkg;

  // Controller states: idle/accepting writes, one-cycle compare, one-cycle repair.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StScrub = 2'd2
  } tmr_state_e;

  // Lane selectors used by the fault-injection port.
  localparam logic [1:0] LANE_A = 2'd0;
  localparam logic [1:0] LANE_B = 2'd1;
  localparam logic [1:0] LANE_C = 2'd2;

  // Default parameter values for tmr_scrub_reg.
  localparam int unsigned DefWidth       = 8;
  localparam int unsigned DefScrubPeriod = 16;
  localparam int unsigned DefErrCntW     = 8;

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out
);

  assign out = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/tmr_scrub_reg.sv
// Triple-redundant register with periodic scrubbing.
// Three lanes hold the same value; a majority vote is always presented on voted.
// Every SCRUB_PERIOD idle cycles the lanes are compared and, if they disagree,
// all lanes are rewritten with the voted value and the error counter advances.
// Optional build macro TMR_FAULT_INJ_EN adds the inj_* ports for XOR fault injection.
module tmr_scrub_reg
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned SCRUB_PERIOD = DefScrubPeriod,
  parameter int unsigned ERR_CNT_W    = DefErrCntW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
`ifdef TMR_FAULT_INJ_EN
  input  logic                 inj_en,
  input  logic [1:0]           inj_lane,
  input  logic [WIDTH-1:0]     inj_mask,
`endif
  output logic [WIDTH-1:0]     copy_a,
  output logic [WIDTH-1:0]     copy_b,
  output logic [WIDTH-1:0]     copy_c,
  output logic [WIDTH-1:0]     voted,
  output logic                 err_flag,
  output logic                 uncorr_flag,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  // Timer wide enough for the largest legal period (255).
  localparam logic [7:0] TimerLast = 8'(SCRUB_PERIOD - 1);

  tmr_state_e st_q, st_d;

  logic [WIDTH-1:0]     lane_a_q, lane_a_d;
  logic [WIDTH-1:0]     lane_b_q, lane_b_d;
  logic [WIDTH-1:0]     lane_c_q, lane_c_d;
  logic [7:0]           timer_q, timer_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 uncorr_q, uncorr_d;

  logic wr_fire;
  logic timer_done;
  logic lanes_agree;
  logic lanes_split;

  tmr_vote #(
    .WIDTH(WIDTH)
  ) u_vote (
    .a  (lane_a_q),
    .b  (lane_b_q),
    .c  (lane_c_q),
    .out(voted)
  );

  assign wr_fire     = in_valid && (st_q == StIdle);
  assign timer_done  = (timer_q == TimerLast);
  assign lanes_agree = (lane_a_q == lane_b_q) && (lane_b_q == lane_c_q);
  // No pair matches: the vote is a bit-mix, not a trusted value.
  assign lanes_split = (lane_a_q != lane_b_q) && (lane_b_q != lane_c_q) &&
                       (lane_a_q != lane_c_q);

  assign copy_a      = lane_a_q;
  assign copy_b      = lane_b_q;
  assign copy_c      = lane_c_q;
  assign err_cnt     = err_cnt_q;
  assign uncorr_flag = uncorr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state logic; a write in the expiry cycle keeps the FSM idle.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:  if (!wr_fire && timer_done) st_d = StCheck;
      StCheck: st_d = lanes_agree ? StIdle : StScrub;
      StScrub: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    err_flag = 1'b0;
    unique case (st_q)
      StIdle:  in_ready = 1'b1;
      StCheck: busy     = 1'b1;
      StScrub: begin
        busy     = 1'b1;
        err_flag = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  // Datapath next-state: lanes, scrub timer, error counter and sticky flag.
  always_comb begin
    lane_a_d  = lane_a_q;
    lane_b_d  = lane_b_q;
    lane_c_d  = lane_c_q;
    timer_d   = 8'd0;
    err_cnt_d = err_cnt_q;
    uncorr_d  = uncorr_q;

    if (st_q == StIdle && !wr_fire && !timer_done) begin
      timer_d = timer_q + 8'd1;
    end

    if (wr_fire) begin
      lane_a_d = in_data;
      lane_b_d = in_data;
      lane_c_d = in_data;
    end else if (st_q == StScrub) begin
      lane_a_d = voted;
      lane_b_d = voted;
      lane_c_d = voted;
`ifdef TMR_FAULT_INJ_EN
    end else if (inj_en) begin
      // Injection only lands when no write or repair owns the lanes this cycle.
      case (inj_lane)
        LANE_A:  lane_a_d = lane_a_q ^ inj_mask;
        LANE_B:  lane_b_d = lane_b_q ^ inj_mask;
        LANE_C:  lane_c_d = lane_c_q ^ inj_mask;
        default: ;
      endcase
`endif
    end

    if (st_q == StScrub && err_cnt_q != {ERR_CNT_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    if (st_q == StCheck && lanes_split) begin
      uncorr_d = 1'b1;
    end
  end

  // Datapath registers; reset abandons any in-flight repair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_a_q  <= '0;
      lane_b_q  <= '0;
      lane_c_q  <= '0;
      timer_q   <= 8'd0;
      err_cnt_q <= '0;
      uncorr_q  <= 1'b0;
    end else begin
      lane_a_q  <= lane_a_d;
      lane_b_q  <= lane_b_d;
      lane_c_q  <= lane_c_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      uncorr_q  <= uncorr_d;
    end
  end

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Scoreboard bench for tmr_scrub_reg: stimulus pushes expectations, a negedge
// monitor pops them on writes, scrub completions and tagged cycles.
// A second instance with a 2-bit error counter shares all stimulus.
module tb_tmr_scrub_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
`ifdef TMR_FAULT_INJ_EN
  logic       inj_en;
  logic [1:0] inj_lane;
  logic [7:0] inj_mask;
`else
  logic [7:0] frc_val;
`endif

  logic       in_ready, err_flag, uncorr_flag, busy;
  logic [7:0] copy_a, copy_b, copy_c, voted, err_cnt;
  logic       in_ready2, err_flag2, uncorr_flag2, busy2;
  logic [7:0] copy_a2, copy_b2, copy_c2, voted2;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  tmr_scrub_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef TMR_FAULT_INJ_EN
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
`endif
    .copy_a(copy_a), .copy_b(copy_b), .copy_c(copy_c), .voted(voted),
    .err_flag(err_flag), .uncorr_flag(uncorr_flag), .err_cnt(err_cnt), .busy(busy)
  );

  tmr_scrub_reg #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
`ifdef TMR_FAULT_INJ_EN
    .inj_en(inj_en), .inj_lane(inj_lane), .inj_mask(inj_mask),
`endif
    .copy_a(copy_a2), .copy_b(copy_b2), .copy_c(copy_c2), .voted(voted2),
    .err_flag(err_flag2), .uncorr_flag(uncorr_flag2), .err_cnt(err_cnt2), .busy(busy2)
  );

  typedef struct {int cyc; int sig; logic [31:0] exp;} snap_t;
  typedef struct {logic [7:0] val; logic [31:0] cnt; logic [31:0] cnt2;} scr_t;

  localparam int SA = 0, SB = 1, SC = 2, SV = 3, SFLAG = 4, SUNC = 5, SCNT = 6;
  localparam int SBUSY = 7, SRDY = 8, SCNT2 = 9, SBUSY2 = 10, SRDY2 = 11;
  localparam int SUNC2 = 12, SFLAG2 = 13;

  snap_t      snap_q[$];
  logic [7:0] wr_q[$];
  scr_t       scr_q[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  bit hs_prev = 1'b0;
  bit flag_prev = 1'b0;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      SA:      return 32'(copy_a);
      SB:      return 32'(copy_b);
      SC:      return 32'(copy_c);
      SV:      return 32'(voted);
      SFLAG:   return 32'(err_flag);
      SUNC:    return 32'(uncorr_flag);
      SCNT:    return 32'(err_cnt);
      SBUSY:   return 32'(busy);
      SRDY:    return 32'(in_ready);
      SCNT2:   return 32'(err_cnt2);
      SBUSY2:  return 32'(busy2);
      SRDY2:   return 32'(in_ready2);
      SUNC2:   return 32'(uncorr_flag2);
      default: return 32'(err_flag2);
    endcase
  endfunction

  function automatic string sig_name(int s);
    case (s)
      SA: return "copy_a";       SB: return "copy_b";     SC: return "copy_c";
      SV: return "voted";        SFLAG: return "err_flag"; SUNC: return "uncorr_flag";
      SCNT: return "err_cnt";    SBUSY: return "busy";    SRDY: return "in_ready";
      SCNT2: return "err_cnt2";  SBUSY2: return "busy2";  SRDY2: return "in_ready2";
      SUNC2: return "uncorr2";   default: return "err_flag2";
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the matching expectation whenever the DUT presents a result.
  always @(negedge clk) begin : monitor
    logic [7:0] d;
    scr_t       s;
    snap_t      sn;
    if (hs_prev) begin
      if (wr_q.size() == 0) chk("unexpected_write", 32'(wr_q.size()), 1);
      else begin
        d = wr_q.pop_front();
        chk("wr_copy_a", 32'(copy_a), 32'(d));
        chk("wr_copy_b", 32'(copy_b), 32'(d));
        chk("wr_copy_c", 32'(copy_c), 32'(d));
        chk("wr_voted", 32'(voted), 32'(d));
        chk("wr2_lanes", {8'h0, copy_a2, copy_b2, copy_c2}, {8'h0, d, d, d});
        chk("wr2_voted", 32'(voted2), 32'(d));
      end
    end
    hs_prev = in_valid && in_ready;
    if (flag_prev) begin
      if (scr_q.size() == 0) chk("unexpected_scrub", 32'(scr_q.size()), 1);
      else begin
        s = scr_q.pop_front();
        chk("scrub_copy_a", 32'(copy_a), 32'(s.val));
        chk("scrub_copy_b", 32'(copy_b), 32'(s.val));
        chk("scrub_copy_c", 32'(copy_c), 32'(s.val));
        chk("scrub_err_cnt", 32'(err_cnt), s.cnt);
        chk("scrub_err_cnt2", 32'(err_cnt2), s.cnt2);
        chk("err_flag_one_cycle", 32'(err_flag), 0);
      end
    end
    flag_prev = err_flag;
    if (err_flag) pulses++;
    while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
      sn = snap_q.pop_front();
      chk(sig_name(sn.sig), get_sig(sn.sig), sn.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(int s, logic [31:0] e);
    snap_q.push_back('{cyc, s, e});
  endtask

  task automatic expect_reset_vals();
    expect_now(SA, 0);   expect_now(SB, 0);    expect_now(SC, 0);    expect_now(SV, 0);
    expect_now(SFLAG, 0); expect_now(SUNC, 0); expect_now(SCNT, 0);  expect_now(SBUSY, 0);
    expect_now(SRDY, 1); expect_now(SCNT2, 0); expect_now(SBUSY2, 0); expect_now(SRDY2, 1);
    expect_now(SUNC2, 0); expect_now(SFLAG2, 0);
  endtask

  task automatic write(logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    wr_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Flip mask bits in one lane of both instances across exactly one clock edge.
  task automatic corrupt(int lane, logic [7:0] mask, logic [7:0] cur);
`ifdef TMR_FAULT_INJ_EN
    inj_en   = 1'b1;
    inj_lane = 2'(lane);
    inj_mask = mask;
    tick();
    inj_en   = 1'b0;
    inj_mask = 8'h00;
`else
    @(negedge clk);
    #1;
    frc_val = cur ^ mask;
    case (lane)
      0:       begin force dut.lane_a_q = frc_val; force dut2.lane_a_q = frc_val; end
      1:       begin force dut.lane_b_q = frc_val; force dut2.lane_b_q = frc_val; end
      default: begin force dut.lane_c_q = frc_val; force dut2.lane_c_q = frc_val; end
    endcase
    tick();
    case (lane)
      0:       begin release dut.lane_a_q; release dut2.lane_a_q; end
      1:       begin release dut.lane_b_q; release dut2.lane_b_q; end
      default: begin release dut.lane_c_q; release dut2.lane_c_q; end
    endcase
`endif
  endtask

  task automatic wait_scrub(string name);
    for (int i = 0; i < 24 && scr_q.size() != 0; i++) tick();
    chk(name, 32'(scr_q.size()), 0);
    scr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
`ifdef TMR_FAULT_INJ_EN
    inj_en = 1'b0; inj_lane = 2'd0; inj_mask = 8'h00;
`endif
    tick();
    expect_reset_vals();
    tick();
    rst = 1'b0;
    expect_now(SRDY, 1); expect_now(SBUSY, 0);
    tick();

    // Basic write: all lanes and vote carry the value one cycle later.
    write(8'hA5);
    expect_now(SCNT, 0);

    // Single-lane upset on B is outvoted, then repaired by a scrub.
    corrupt(1, 8'h0F, 8'hA5);
    expect_now(SB, 8'hAA); expect_now(SA, 8'hA5); expect_now(SV, 8'hA5);
    expect_now(SUNC, 0);
    scr_q.push_back('{8'hA5, 1, 1});
    wait_scrub("scrub_lane_b");
    expect_now(SUNC, 0); expect_now(SCNT, 1); expect_now(SB, 8'hA5);

    // Three pairwise-different lanes: uncorrectable flag, vote still A5.
    write(8'hA5);
    corrupt(0, 8'h01, 8'hA5);
    corrupt(1, 8'h02, 8'hA5);
    corrupt(2, 8'h04, 8'hA5);
    expect_now(SA, 8'hA4); expect_now(SB, 8'hA7); expect_now(SC, 8'hA1);
    expect_now(SV, 8'hA5); expect_now(SUNC, 0);
    scr_q.push_back('{8'hA5, 2, 2});
    wait_scrub("scrub_split");
    expect_now(SUNC, 1); expect_now(SUNC2, 1); expect_now(SCNT, 2); expect_now(SCNT2, 2);

    // Back-to-back writes keep the scrub timer from ever expiring.
    for (int i = 0; i < 40; i++) begin
      write(8'(8'h10 + i));
      expect_now(SBUSY, 0);
      expect_now(SRDY, 1);
    end
    // Write landing on the expiry cycle wins; no CHECK follows.
    repeat (15) tick();
    write(8'h5A);
    expect_now(SBUSY, 0);
    tick();
    expect_now(SBUSY, 0); expect_now(SRDY, 1);

    // Three more repairs: 8-bit counter reaches 5, 2-bit counter pins at 3.
    for (int k = 0; k < 3; k++) begin
      corrupt(k, 8'h80, 8'h5A);
      scr_q.push_back('{8'h5A, 32'(3 + k), 3});
      wait_scrub("scrub_sat");
    end
    expect_now(SCNT, 5); expect_now(SCNT2, 3); expect_now(SUNC, 1);

    cur = 8'h5A;
`ifdef TMR_FAULT_INJ_EN
    // Injection coinciding with a write is dropped.
    in_valid = 1'b1; in_data = 8'h77; wr_q.push_back(8'h77);
    inj_en = 1'b1; inj_lane = 2'd0; inj_mask = 8'hFF;
    tick();
    in_valid = 1'b0; inj_en = 1'b0; inj_mask = 8'h00;
    cur = 8'h77;
`endif

    // Reset during SCRUB aborts the repair and clears everything at once.
    corrupt(0, 8'h01, cur);
    for (int i = 0; i < 24 && !busy; i++) tick();
    chk("check_reached", 32'(busy), 1);
    tick();
    rst = 1'b1;
    expect_reset_vals();
    tick();
    rst = 1'b0;
    tick();
    expect_reset_vals();
    write(8'h3C);
    expect_now(SCNT, 0);
    repeat (2) tick();

    chk("err_pulses", 32'(pulses), 5);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    chk("snap_q_drained", 32'(snap_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
